// File: rtl/smarthome_uart_pkg.sv
// Shared UART definitions for the SmartHome host link.
// Used by both the byte transmitter and the receiver.
package smarthome_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx_fifo.sv
// Small synchronous byte FIFO with full/empty flags.
// Push is refused when full, judged before any same-edge pop.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter fed by a byte strobe through a small FIFO.
// Back-to-back frames run stop bit straight into the next start bit.
module uart_byte_tx
    import smarthome_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] txdata,
    input  logic       dataValid,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     head;
    logic           empty;
    logic           full;
    logic           pop;
    logic           bit_end;
    logic           push_ok;

    assign bit_end   = (baud_cnt == LAST);
    assign pop       = !empty && ((state == IDLE) ||
                                  (state == STOP && bit_end));
    assign push_ok   = dataValid && !full;
    assign fifo_full = full;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (dataValid),
        .pop  (pop),
        .din  (txdata),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= dataValid && full;
            unique case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!empty) begin
                        shift <= head;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= push_ok;
                    end
                end
                START: begin
                    busy <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    busy <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when more is queued
                        if (!empty) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= push_ok;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serialises command/status bytes from the SmartHome control logic onto the UART line back to the host, as 8N1 frames. It consumes the `txdata`/`dataValid` byte strobe produced by the control core and drives the serial `tx` pin. It is the transmit end of the same byte interface whose receive side feeds `rxdata`. A small FIFO absorbs strobes that arrive while a frame is in flight.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency.
- `BAUD`, default 9600: line rate. `CLKS_PER_BIT` = `CLK_HZ/BAUD`, using integer division (5208 at the defaults).
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of 2, ≥2.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `txdata`, input, 8: byte to send; sampled when `dataValid`=1.
- `dataValid`, input, 1: write strobe. Each cycle it is high enqueues one byte.
- `tx`, output, 1: serial line, idle high.
- `busy`, output, 1: high while a frame is in progress or the FIFO is non-empty.
- `fifo_full`, output, 1: FIFO holds `FIFO_DEPTH` bytes.
- `overflow`, output, 1: one-cycle pulse when a strobed byte is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `overflow`=0, FIFO empty, FSM in IDLE, bit and baud counters 0.
- FIFO write:
  - On a rising edge with `dataValid`=1, `txdata` is pushed unless the FIFO is full.
  - Fullness is judged before any pop on the same edge.
  - If full, the byte is dropped and `overflow`=1 for that one cycle only.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty: pop the head into the shift register, go to START, set `tx`=0.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - Drive `tx` = shift[0], LSB first, for `CLKS_PER_BIT` cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - Hold `tx`=1 for `CLKS_PER_BIT` cycles.
  - At the end of the period: if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- `tx` is a registered output; it never glitches between bit periods.
- Baud counter width is `$clog2(CLKS_PER_BIT)`; it wraps to 0 at `CLKS_PER_BIT-1`.
- Reset mid-frame: the frame is abandoned, `tx` returns to 1 asynchronously, FIFO contents are discarded, and nothing resumes after release.

## Timing
- Latency: a strobe at edge N into an empty FIFO with the FSM idle gives `tx`=0 after edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames are contiguous: the stop bit of one is followed immediately by the start bit of the next.
- `busy` is registered and falls on the edge that returns the FSM to IDLE with an empty FIFO.
- `fifo_full` reflects the count after that edge's push/pop.
- `overflow` is never high for two consecutive cycles unless dropped strobes are consecutive.

## Structure
- Shared package `smarthome_uart_pkg` holds:
  - the FSM state enum `uart_tx_state_t` (IDLE/START/DATA/STOP);
  - constants `UART_DATA_BITS`=8 and `UART_STOP_BITS`=1;
  - function `clks_per_bit(clk_hz, baud)`.
- The receiver side uses the same package.
- One sub-module: `byte_fifo` (parameterised depth/width, synchronous push/pop, `full`/`empty` flags, async active-low reset), instantiated once.

## Test plan
All scenarios use `CLK_HZ`=1000, `BAUD`=100, so `CLKS_PER_BIT`=10.
- Single byte: one strobe of 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. Start falls after edge N+1, and `busy` falls exactly 100 cycles after `tx` first goes low.
- Back-to-back: 0x00 and 0xFF strobed on consecutive cycles → the two frames occupy 200 contiguous cycles: start, 8×0, stop, start, 8×1, stop. No idle bit between them, and no `overflow`.
- Overflow: 6 consecutive strobes (0x01–0x06) with depth 4 → the 6th strobe is dropped with a single `overflow` pulse; frames 0x01–0x05 are sent in order; `fifo_full`=1 during cycles N+4..N+5.
- Held strobe: `dataValid` high for 3 cycles with `txdata` 0x10, 0x20, 0x30 → three contiguous frames in that order.
- Reset mid-frame: `rst_n` pulled low during data bit 3 of 0x55 with two bytes queued → `tx`=1 and `busy`=0 immediately. After release, `tx` stays 1 for 500 cycles with no frame.
- Idle line: no strobes for 1000 cycles after reset → `tx`=1, `busy`=0, `overflow`=0 throughout.
